// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD display scanner: a sequential double-dabble converter feeding a
// time-multiplexed seven-segment scan with leading-zero blanking, decimal points and blink.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 2**19,
  parameter int BLINK_DIV   = 16,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [BIN_WIDTH-1:0]  number_i,
  input  logic [NUM_DIGITS-1:0] dp_i,
  input  logic                  blink_en_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [3:0]            output_number,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic                  dp_o
);

  localparam int BCD_W   = NUM_DIGITS * 4;
  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int SLOT_W  = $clog2(NUM_DIGITS);
  localparam int FRAME_W = $clog2(BLINK_DIV + 1);
  localparam int SH_W    = $clog2(BIN_WIDTH + 1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0]      MAX_VAL = pow10(NUM_DIGITS) - 32'd1;
  localparam logic [BCD_W-1:0] NINES   = {NUM_DIGITS{4'h9}};

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = v[i*4 +: 4];
    end
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  state_t                state_r;
  logic [BIN_WIDTH-1:0]  bin_r;
  logic [BCD_W-1:0]      bcd_r;
  logic [BCD_W-1:0]      adj_s;
  logic [BCD_W-1:0]      disp_r;
  logic [SH_W-1:0]       sh_cnt_r;
  logic                  ovf_r;
  logic                  busy_r;
  logic                  overflow_r;
  logic [CNT_W-1:0]      ref_cnt_r;
  logic [SLOT_W-1:0]     slot_r;
  logic [FRAME_W-1:0]    frame_cnt_r;
  logic                  phase_r;
  logic                  tick_s;
  logic                  last_slot_s;
  logic                  frame_end_s;
  logic                  zero_above_s;
  logic                  lz_blank_s;
  logic                  dark_s;

  assign adj_s       = bcd_adjust(bcd_r);
  assign tick_s      = (ref_cnt_r == CNT_W'(REFRESH_DIV - 1));
  assign last_slot_s = (slot_r == SLOT_W'(NUM_DIGITS - 1));
  assign frame_end_s = tick_s & last_slot_s;
  assign busy_o      = busy_r;
  assign overflow_o  = overflow_r;

  // Conversion FSM: capture, BIN_WIDTH shift steps, then commit to the display register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      bin_r      <= '0;
      bcd_r      <= '0;
      sh_cnt_r   <= '0;
      ovf_r      <= 1'b0;
      disp_r     <= '0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_i) begin
            bin_r    <= number_i;
            bcd_r    <= '0;
            sh_cnt_r <= '0;
            ovf_r    <= (32'(number_i) > MAX_VAL);
            busy_r   <= 1'b1;
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_r    <= {adj_s[BCD_W-2:0], bin_r[BIN_WIDTH-1]};
          bin_r    <= {bin_r[BIN_WIDTH-2:0], 1'b0};
          sh_cnt_r <= sh_cnt_r + SH_W'(1);
          if (sh_cnt_r == SH_W'(BIN_WIDTH - 1)) state_r <= COMMIT;
        end
        COMMIT: begin
          disp_r     <= ovf_r ? NINES : bcd_r;
          overflow_r <= ovf_r;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Refresh prescaler, slot rotation, frame counting and blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt_r   <= '0;
      slot_r      <= '0;
      frame_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else begin
      ref_cnt_r <= tick_s ? '0 : ref_cnt_r + CNT_W'(1);
      if (tick_s) slot_r <= last_slot_s ? '0 : slot_r + SLOT_W'(1);
      if (!blink_en_i) begin
        frame_cnt_r <= '0;
        phase_r     <= 1'b0;
      end else if (frame_end_s) begin
        if (frame_cnt_r == FRAME_W'(BLINK_DIV - 1)) begin
          frame_cnt_r <= '0;
          phase_r     <= ~phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
      end
    end
  end

  // Active-slot decode; a slot is dark when it is a blanked leading zero or blinked off.
  always_comb begin
    zero_above_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_above_s = zero_above_s & ~((i >= int'(slot_r)) & (disp_r[i*4 +: 4] != 4'd0));
    end
    lz_blank_s = (LZ_BLANK != 0) && (slot_r != '0) && zero_above_s && !dp_i[slot_r];
    dark_s     = lz_blank_s | (blink_en_i & phase_r);
    if (dark_s) begin
      digit_select  = '1;
      output_number = 4'hF;
      dp_o          = 1'b0;
    end else begin
      digit_select  = ~(NUM_DIGITS'(1) << slot_r);
      output_number = disp_r[{slot_r, 2'b00} +: 4];
      dp_o          = dp_i[slot_r];
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: stimulus pushes hand-computed conversion and scan expectations,
// monitors pop them when busy_o falls or when the bench's own slot timing reaches them.
module tb_bcd_display_scanner;

  typedef struct { int slot; logic [7:0] ds; logic [3:0] num; logic dp; logic ovf; } scan_t;
  typedef struct { int len; logic ovf; } conv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load0, load1, blink0, blink1;
  logic [13:0] num0;
  logic [19:0] num1;
  logic [3:0]  dp0;
  logic [5:0]  dp1;
  logic        busy0, ovf0, dpo0, busy1, ovf1, dpo1;
  logic [3:0]  on0, on1, ds0;
  logic [5:0]  ds1;

  scan_t sq0[$], sq1[$];
  conv_t cq0[$], cq1[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  bcd_display_scanner #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1)) dut0 (
    .clk(clk), .reset(reset), .load_i(load0), .number_i(num0), .dp_i(dp0), .blink_en_i(blink0),
    .busy_o(busy0), .overflow_o(ovf0), .output_number(on0), .digit_select(ds0), .dp_o(dpo0));

  bcd_display_scanner #(.NUM_DIGITS(6), .BIN_WIDTH(20), .REFRESH_DIV(4), .BLINK_DIV(2), .LZ_BLANK(1)) dut1 (
    .clk(clk), .reset(reset), .load_i(load1), .number_i(num1), .dp_i(dp1), .blink_en_i(blink1),
    .busy_o(busy1), .overflow_o(ovf1), .output_number(on1), .digit_select(ds1), .dp_o(dpo1));

  always #5 clk = ~clk;

  // Reference refresh timeline: cycles since reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor for the 4-digit instance.
  initial begin
    int    blen;
    conv_t c;
    scan_t s;
    blen = 0;
    forever begin
      @(negedge clk);
      if (busy0) blen++;
      else if (blen > 0) begin
        total++;
        if (cq0.size() == 0) begin
          bad++;
          $display("FAIL conv0 unexpected busy pulse: got len=%0d, wanted none", blen);
        end else begin
          c = cq0.pop_front();
          if (blen != c.len || ovf0 !== c.ovf) begin
            bad++;
            $display("FAIL conv0 busy_len/overflow: got %0d/%b, wanted %0d/%b", blen, ovf0, c.len, c.ovf);
          end
        end
        blen = 0;
      end
      if (reset && (cyc % 4) == 1 && sq0.size() > 0 && sq0[0].slot == (cyc / 4) % 4) begin
        s = sq0.pop_front();
        total++;
        if (ds0 !== s.ds[3:0] || on0 !== s.num || dpo0 !== s.dp || ovf0 !== s.ovf) begin
          bad++;
          $display("FAIL scan0 slot%0d sel/num/dp/ovf: got %b/%h/%b/%b, wanted %b/%h/%b/%b",
                   s.slot, ds0, on0, dpo0, ovf0, s.ds[3:0], s.num, s.dp, s.ovf);
        end
      end
    end
  end

  // Monitor for the 6-digit instance.
  initial begin
    int    blen;
    conv_t c;
    scan_t s;
    blen = 0;
    forever begin
      @(negedge clk);
      if (busy1) blen++;
      else if (blen > 0) begin
        total++;
        if (cq1.size() == 0) begin
          bad++;
          $display("FAIL conv1 unexpected busy pulse: got len=%0d, wanted none", blen);
        end else begin
          c = cq1.pop_front();
          if (blen != c.len || ovf1 !== c.ovf) begin
            bad++;
            $display("FAIL conv1 busy_len/overflow: got %0d/%b, wanted %0d/%b", blen, ovf1, c.len, c.ovf);
          end
        end
        blen = 0;
      end
      if (reset && (cyc % 4) == 1 && sq1.size() > 0 && sq1[0].slot == (cyc / 4) % 6) begin
        s = sq1.pop_front();
        total++;
        if (ds1 !== s.ds[5:0] || on1 !== s.num || dpo1 !== s.dp || ovf1 !== s.ovf) begin
          bad++;
          $display("FAIL scan1 slot%0d sel/num/dp/ovf: got %b/%h/%b/%b, wanted %b/%h/%b/%b",
                   s.slot, ds1, on1, dpo1, ovf1, s.ds[5:0], s.num, s.dp, s.ovf);
        end
      end
    end
  end

  task automatic exp_conv0(input int len, input logic ovf);
    conv_t c;
    c.len = len; c.ovf = ovf;
    cq0.push_back(c);
  endtask

  task automatic exp_conv1(input int len, input logic ovf);
    conv_t c;
    c.len = len; c.ovf = ovf;
    cq1.push_back(c);
  endtask

  // ds/num hold slot3..slot0 nibbles, slot 0 in the low nibble.
  task automatic exp_frame0(input logic [15:0] ds, input logic [15:0] num, input logic [3:0] dp, input logic ovf);
    scan_t e;
    for (int s = 0; s < 4; s++) begin
      e.slot = s; e.ds = 8'(ds[s*4 +: 4]); e.num = num[s*4 +: 4]; e.dp = dp[s]; e.ovf = ovf;
      sq0.push_back(e);
    end
  endtask

  task automatic exp_frame1(input logic [35:0] ds, input logic [23:0] num, input logic ovf);
    scan_t e;
    for (int s = 0; s < 6; s++) begin
      e.slot = s; e.ds = 8'(ds[s*6 +: 6]); e.num = num[s*4 +: 4]; e.dp = 1'b0; e.ovf = ovf;
      sq1.push_back(e);
    end
  endtask

  task automatic do_load0(input logic [13:0] v);
    @(negedge clk);
    num0 = v; load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
  endtask

  task automatic do_load1(input logic [19:0] v);
    @(negedge clk);
    num1 = v; load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sq0.size() + sq1.size() + cq0.size() + cq1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if ((sq0.size() + sq1.size() + cq0.size() + cq1.size()) != 0) begin
      total++;
      bad++;
      $display("FAIL drain timeout: got %0d pending expectations, wanted 0",
               sq0.size() + sq1.size() + cq0.size() + cq1.size());
      sq0.delete(); sq1.delete(); cq0.delete(); cq1.delete();
    end
  endtask

  initial begin
    logic [35:0] ds6;
    int          n;
    ds6 = {6'b011111, 6'b101111, 6'b110111, 6'b111011, 6'b111101, 6'b111110};
    reset = 1'b0; load0 = 1'b0; load1 = 1'b0; blink0 = 1'b0; blink1 = 1'b0;
    num0 = 14'd0; num1 = 20'd0; dp0 = 4'd0; dp1 = 6'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state, then basic conversions, blanking and decimal points.
    exp_frame0(16'hFFFE, 16'hFFF0, 4'b0000, 1'b0);
    drain();
    exp_conv0(15, 1'b0); do_load0(14'd1234); drain();
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0); drain();
    exp_conv0(15, 1'b0); do_load0(14'd42); drain();
    exp_frame0(16'hFFDE, 16'hFF42, 4'b0000, 1'b0); drain();
    dp0 = 4'b0100;
    exp_frame0(16'hFBDE, 16'hF042, 4'b0100, 1'b0); drain();
    dp0 = 4'b0000;

    // Overflow saturation and recovery.
    exp_conv0(15, 1'b1); do_load0(14'd12000); drain();
    exp_frame0(16'h7BDE, 16'h9999, 4'b0000, 1'b1); drain();
    exp_conv0(15, 1'b0); do_load0(14'd7); drain();
    exp_frame0(16'hFFFE, 16'hFFF7, 4'b0000, 1'b0); drain();

    // A load while busy is dropped.
    exp_conv0(15, 1'b0);
    do_load0(14'd1234);
    @(negedge clk);
    do_load0(14'd5);
    drain();
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0); drain();

    // Reset in the middle of SHIFT aborts the conversion.
    exp_conv0(4, 1'b0);
    do_load0(14'd9876);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (busy0 !== 1'b0 || ds0 !== 4'b1110 || on0 !== 4'h0) begin
      bad++;
      $display("FAIL abort_async busy/sel/num: got %b/%b/%h, wanted 0/1110/0", busy0, ds0, on0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_frame0(16'hFFFE, 16'hFFF0, 4'b0000, 1'b0); drain();

    // Blink: two frames lit, two dark; dropping blink_en mid-dark relights at once.
    exp_conv0(15, 1'b0); do_load0(14'd1234); drain();
    n = 0;
    while ((cyc % 16) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    blink0 = 1'b1;
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    exp_frame0(16'hFFFF, 16'hFFFF, 4'b0000, 1'b0);
    exp_frame0(16'hFFFF, 16'hFFFF, 4'b0000, 1'b0);
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    exp_frame0(16'hFFFF, 16'hFFFF, 4'b0000, 1'b0);
    drain();
    blink0 = 1'b0;
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    exp_frame0(16'h7BDE, 16'h1234, 4'b0000, 1'b0);
    drain();

    // Six-digit instance: full-scale value, slot wrap, then overflow.
    exp_conv1(21, 1'b0); do_load1(20'd999999); drain();
    exp_frame1(ds6, 24'h999999, 1'b0);
    exp_frame1(ds6, 24'h999999, 1'b0);
    drain();
    exp_conv1(21, 1'b1); do_load1(20'd1000000); drain();
    exp_frame1(ds6, 24'h999999, 1'b1); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
